mem_stage_ctrl: RTL and testbench
=================================

// Module: mem_stage_ctrl
// PURPOSE
//  Parametrised data-memory stage for the MIPS datapath. It sits between the ALU/EX output and the WB mux.
//  - Supports byte, half and word loads/stores, little-endian, with sign or zero extension on loads.
//  - Models a memory with a fixed access latency through a req/ready -> resp_valid handshake.
//  - busy stalls the upstream pipeline while an access is outstanding.
// PARAMETERS
//  DEPTH    1024  number of 32-bit words; power of 2, >=4
//  LATENCY  1     cycles from accept edge to resp_valid; 1..15
//  ADDR_W   32    width of the byte address input
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       synchronous, active-high reset
//  req          in   1       access request, sampled when ready=1
//  ready        out  1       1 only in IDLE; accept = req & ready
//  busy         out  1       ~ready; pipeline stall
//  Mem_WrEn     in   1       1=store, 0=load
//  Mem_Size     in   2       00 byte, 01 half, 10 word, 11 treated as word
//  Mem_Signed   in   1       loads: 1 sign-extend, 0 zero-extend
//  ALU_MEM_Addr in   ADDR_W  byte address
//  MEM_DataIn   in   32      store data, right-aligned (byte=[7:0], half=[15:0])
//  resp_valid   out  1       one-cycle pulse: access complete
//  MEM_DataOut  out  32      load result, valid with resp_valid; 0 for stores
//  fault        out  1       misaligned access; valid with resp_valid
// BEHAVIOUR
//  - Reset: state=IDLE, cnt=0, resp_valid=0, MEM_DataOut=0, fault=0. RAM contents are not reset.
//  - Reset mid-access aborts the access. An uncommitted store is dropped.
//  - FSM IDLE -> WAIT -> RESP -> IDLE:
//    - IDLE: on accept, capture Mem_WrEn, Mem_Size, Mem_Signed, ALU_MEM_Addr and MEM_DataIn. Load cnt=LATENCY-1.
//    - From IDLE, go to RESP if LATENCY=1, else to WAIT.
//    - WAIT: decrement cnt; go to RESP when cnt reaches 1.
//  - Commit on the edge that enters RESP:
//    - Store: byte-enabled RAM write.
//    - Load: RAM read, lane extraction and extension, result registered into MEM_DataOut.
//  - RESP lasts exactly one cycle with resp_valid=1. Outputs hold their values afterwards until the next commit.
//  - resp_valid is high in the cycle that starts LATENCY edges after the accept edge.
//  - Throughput is one access per LATENCY+1 cycles. req is ignored while ready=0; there is no queueing.
//  - Word index = addr[$clog2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH*4.
//  - Byte lane = addr[1:0]:
//    - Byte store writes lane addr[1:0] only.
//    - Half store writes lanes {addr[1],0} and {addr[1],1}.
//    - Word store writes all four lanes.
//  - Load extension is applied from bit 7 (byte) or bit 15 (half). Word loads ignore Mem_Signed.
// CONFIGURATION
//  MEM_STAGE_ALIGN_CHECK_EN defined:
//    - A half access with addr[0]=1, or a word access with addr[1:0]!=0, raises fault=1 with resp_valid.
//    - On fault: no RAM write, MEM_DataOut=0, latency unchanged.
//  MEM_STAGE_ALIGN_CHECK_EN undefined:
//    - fault is tied to 0.
//    - Half accesses ignore addr[0]; word accesses ignore addr[1:0].
// STRUCTURE
//  - mem_stage_defs.vh (shared header): size encodings SZ_BYTE/SZ_HALF/SZ_WORD, FSM state codes, lane-select localparams.
//  - Sub-module dmem_sram: DEPTH x 32 synchronous RAM with 4 byte-write enables.
//  - Top level holds the FSM, latency counter, lane/extension logic and alignment check.
// TESTING
//  1 LATENCY=1, store word 0x0000001F @0x4, then load word @0x4:
//    -> resp_valid one cycle after each accept; DataOut=0x0000001F.
//  2 Store byte 0x80 @0x5, then signed load byte @0x5 -> 0xFFFFFF80.
//    Unsigned load byte @0x5 -> 0x00000080. Load word @0x4 -> 0x0000801F.
//  3 Store half 0xBEEF @0x2, then signed load half @0x2 -> 0xFFFFBEEF; word @0x0 -> 0xBEEF0000.
//  4 LATENCY=4, load @0xFC3 with DEPTH=1024 -> word index 0x3F0.
//    ready low for 4 cycles; resp_valid 4 cycles after accept. A req held during busy is not accepted until ready=1.
//  5 rst asserted in WAIT of a store of 0x12345678 @0x8:
//    -> after reset resp_valid=0, ready=1; a later load @0x8 returns the prior value.
//  6 ALIGN_CHECK on, word store @0x6 -> fault=1, RAM unchanged. ALIGN_CHECK off -> store lands at word index 1.

Source files
------------

// File: rtl/mem_stage_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl_pkg
//   Shared definitions for the MIPS data-memory stage:
//   - access size encodings (SZ_BYTE / SZ_HALF / SZ_WORD, 2'b11 behaves as word)
//   - FSM state codes (stateT)
//   - byte-lane select constants
//   - helper functions for byte enables, store lane replication, load lane
//     extraction/extension and alignment checking.
//   Used by mem_stage_ctrl and dmem_sram via import mem_stage_ctrl_pkg::*.
// -----------------------------------------------------------------------------
package mem_stage_ctrl_pkg;

    // FSM state codes. The encoding is fixed so a bench or checker can decode
    // the debug state output without referring to the enum.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } stateT;

    // Access size encodings on Mem_Size.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Byte-lane groups (bit i enables byte lane i, lane 0 = bits [7:0]).
    localparam logic [3:0] LANES_LO  = 4'b0011;
    localparam logic [3:0] LANES_HI  = 4'b1100;
    localparam logic [3:0] LANES_ALL = 4'b1111;

    // Byte enables for a store. Half accesses only look at lane[1] and word
    // accesses ignore the lane entirely, so unaligned addresses fold onto the
    // enclosing aligned half/word.
    function automatic logic [3:0] laneEnable(input logic [1:0] size,
                                              input logic [1:0] lane);
        logic [3:0] en;
        case (size)
            SZ_BYTE: en = 4'b0001 << lane;
            SZ_HALF: en = lane[1] ? LANES_HI : LANES_LO;
            default: en = LANES_ALL;
        endcase
        return en;
    endfunction

    // Store data arrives right-aligned; replicate it across the word so that
    // whichever lanes are enabled see the right bytes.
    function automatic logic [31:0] storeData(input logic [1:0]  size,
                                              input logic [31:0] data);
        logic [31:0] d;
        case (size)
            SZ_BYTE: d = {4{data[7:0]}};
            SZ_HALF: d = {2{data[15:0]}};
            default: d = data;
        endcase
        return d;
    endfunction

    // Pick the addressed lane(s) out of a RAM word and extend to 32 bits.
    // Word loads ignore the sign flag.
    function automatic logic [31:0] loadExtract(input logic [31:0] rdata,
                                                input logic [1:0]  size,
                                                input logic [1:0]  lane,
                                                input logic        sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = lane[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_BYTE: r = {{24{sgn & b[7]}}, b};
            SZ_HALF: r = {{16{sgn & h[15]}}, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

    // Natural-alignment check: half needs addr[0]=0, word needs addr[1:0]=0.
    function automatic logic isMisaligned(input logic [1:0] size,
                                          input logic [1:0] lane);
        logic m;
        case (size)
            SZ_BYTE: m = 1'b0;
            SZ_HALF: m = lane[0];
            default: m = (lane != 2'b00);
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_dmem_sram.sv
// -----------------------------------------------------------------------------
// dmem_sram
//   DEPTH x 32-bit data RAM with four byte-write enables. Writes are
//   synchronous on the rising clock edge; the read port is combinational so
//   the controller can extract and register load data on the same edge that
//   commits the access. Contents are not reset.
// Ports
//   clk    in   1                 rising-edge clock
//   addr   in   $clog2(DEPTH)     word index (shared by read and write)
//   we     in   4                 byte-write enables, bit i -> bits [8i+7:8i]
//   wData  in   32                write data (already lane-replicated)
//   rData  out  32                word at addr
// -----------------------------------------------------------------------------
module dmem_sram #(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [3:0]               we,
    input  logic [31:0]              wData,
    output logic [31:0]              rData
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wData[8*i +: 8];
            end
        end
    end

    assign rData = mem[addr];

endmodule

// File: rtl/mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl
//   Data-memory stage between EX and WB of the MIPS datapath. Byte/half/word
//   little-endian loads and stores with sign/zero extension, behind a memory
//   model of fixed access latency.
//
//   Handshake: an access is accepted on a rising edge where req & ready.
//   ready is high only in IDLE; req is ignored otherwise (no queueing) and
//   busy = ~ready stalls the upstream stage. The access completes with a
//   one-cycle resp_valid pulse in the LATENCY-th cycle after the accept cycle;
//   MEM_DataOut and fault are valid with that pulse and hold until the next
//   completion. Throughput is one access per LATENCY+1 cycles.
//
//   Optional feature macro: MEM_STAGE_ALIGN_CHECK_EN
//     defined   : misaligned half/word accesses complete with fault=1, no RAM
//                 write and MEM_DataOut=0.
//     undefined : fault tied to 0; half accesses ignore addr[0], word accesses
//                 ignore addr[1:0].
//
// Parameters
//   DEPTH    number of 32-bit words (power of 2, >= 4)
//   LATENCY  accept-to-response latency in cycles (1..15)
//   ADDR_W   byte address width (must be >= $clog2(DEPTH)+2)
// Ports
//   clk, rst       clock, synchronous active-high reset
//   req            access request
//   ready, busy    accept window / pipeline stall
//   Mem_WrEn       1 store, 0 load
//   Mem_Size       00 byte, 01 half, 10/11 word
//   Mem_Signed     load sign-extension select
//   ALU_MEM_Addr   byte address (wraps modulo DEPTH*4)
//   MEM_DataIn     right-aligned store data
//   resp_valid     one-cycle completion pulse
//   MEM_DataOut    load result (0 for stores and faults)
//   fault          misaligned access flag
//   dbgState       current FSM state
// -----------------------------------------------------------------------------
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    output logic              ready,
    output logic              busy,
    input  logic              Mem_WrEn,
    input  logic [1:0]        Mem_Size,
    input  logic              Mem_Signed,
    input  logic [ADDR_W-1:0] ALU_MEM_Addr,
    input  logic [31:0]       MEM_DataIn,
    output logic              resp_valid,
    output logic [31:0]       MEM_DataOut,
    output logic              fault,
    output stateT             dbgState
);

    localparam int         IDX_W    = $clog2(DEPTH);
    localparam int         LOC_W    = IDX_W + 2;       // word index + byte lane
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    stateT             state;
    stateT             nextState;
    logic [3:0]        cnt;
    logic              accept;

    // Access captured at accept time.
    logic              capWrEn;
    logic [1:0]        capSize;
    logic              capSigned;
    logic [LOC_W-1:0]  capAddr;
    logic [31:0]       capData;

    // Access currently being worked on. In IDLE this is the incoming request,
    // which lets a LATENCY=1 access commit on the accept edge itself.
    logic              curWrEn;
    logic [1:0]        curSize;
    logic              curSigned;
    logic [LOC_W-1:0]  curAddr;
    logic [31:0]       curData;
    logic              curFault;

    logic              commit;
    logic [3:0]        ramWe;
    logic [31:0]       ramRData;

    // Upper address bits are deliberately dropped so addresses wrap.
    if (ADDR_W > LOC_W) begin : gAddrWrap
        logic unusedAddrBits;
        assign unusedAddrBits = ^ALU_MEM_Addr[ADDR_W-1:LOC_W];
    end

    // ---------------------------------------------------------------- FSM ---
    // State register and latency counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= nextState;
            if (accept) begin
                cnt <= CNT_INIT;
            end else if (state == ST_WAIT) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // Next-state logic. WAIT is held while cnt counts LATENCY-1 .. 1, giving
    // LATENCY-1 WAIT cycles before RESP.
    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    nextState = (LATENCY == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd1) begin
                    nextState = ST_RESP;
                end
            end
            ST_RESP: nextState = ST_IDLE;
            default: nextState = ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        ready      = (state == ST_IDLE);
        busy       = (state != ST_IDLE);
        resp_valid = (state == ST_RESP);
        dbgState   = state;
    end

    assign accept = req & ready;

    // ------------------------------------------------------------ capture ---
    always_ff @(posedge clk) begin
        if (rst) begin
            capWrEn   <= 1'b0;
            capSize   <= SZ_BYTE;
            capSigned <= 1'b0;
            capAddr   <= '0;
            capData   <= 32'd0;
        end else if (accept) begin
            capWrEn   <= Mem_WrEn;
            capSize   <= Mem_Size;
            capSigned <= Mem_Signed;
            capAddr   <= ALU_MEM_Addr[LOC_W-1:0];
            capData   <= MEM_DataIn;
        end
    end

    always_comb begin
        if (state == ST_IDLE) begin
            curWrEn   = Mem_WrEn;
            curSize   = Mem_Size;
            curSigned = Mem_Signed;
            curAddr   = ALU_MEM_Addr[LOC_W-1:0];
            curData   = MEM_DataIn;
        end else begin
            curWrEn   = capWrEn;
            curSize   = capSize;
            curSigned = capSigned;
            curAddr   = capAddr;
            curData   = capData;
        end
    end

`ifdef MEM_STAGE_ALIGN_CHECK_EN
    assign curFault = isMisaligned(curSize, curAddr[1:0]);
`else
    assign curFault = 1'b0;
`endif

    // ------------------------------------------------------------- commit ---
    // The access takes effect on the edge that enters RESP. A reset on that
    // same edge wins, so a store in flight is dropped.
    assign commit = (nextState == ST_RESP) && !rst;
    assign ramWe  = (commit && curWrEn && !curFault)
                    ? laneEnable(curSize, curAddr[1:0]) : 4'b0000;

    dmem_sram #(
        .DEPTH (DEPTH)
    ) uSram (
        .clk   (clk),
        .addr  (curAddr[LOC_W-1:2]),
        .we    (ramWe),
        .wData (storeData(curSize, curData)),
        .rData (ramRData)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            MEM_DataOut <= 32'd0;
        end else if (commit) begin
            if (curWrEn || curFault) begin
                MEM_DataOut <= 32'd0;
            end else begin
                MEM_DataOut <= loadExtract(ramRData, curSize, curAddr[1:0], curSigned);
            end
        end
    end

`ifdef MEM_STAGE_ALIGN_CHECK_EN
    logic faultReg;

    always_ff @(posedge clk) begin
        if (rst) begin
            faultReg <= 1'b0;
        end else if (commit) begin
            faultReg <= curFault;
        end
    end

    assign fault = faultReg;
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_ctrl
//   Two instances share clk/rst: index 0 has LATENCY=1, index 1 has LATENCY=4,
//   both DEPTH=1024. Directed table vectors plus hand-written sequences for
//   held-req-during-busy and reset during an outstanding store.
// -----------------------------------------------------------------------------
module tb_mem_stage_ctrl;
    import mem_stage_ctrl_pkg::*;

`ifdef MEM_STAGE_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    typedef struct {
        logic        wrEn;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] expOut;
        logic        expFault;
    } vecT;

    // ------------------------------------------------ clock / reset block ---
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req        [2];
    logic        ready      [2];
    logic        busy       [2];
    logic        wrEn       [2];
    logic [1:0]  memSize    [2];
    logic        memSigned  [2];
    logic [31:0] addr       [2];
    logic [31:0] dataIn     [2];
    logic        respValid  [2];
    logic [31:0] dataOut    [2];
    logic        fault      [2];
    stateT       dbgState   [2];

    mem_stage_ctrl #(.DEPTH(1024), .LATENCY(1), .ADDR_W(32)) dut0 (
        .clk(clk), .rst(rst), .req(req[0]), .ready(ready[0]), .busy(busy[0]),
        .Mem_WrEn(wrEn[0]), .Mem_Size(memSize[0]), .Mem_Signed(memSigned[0]),
        .ALU_MEM_Addr(addr[0]), .MEM_DataIn(dataIn[0]),
        .resp_valid(respValid[0]), .MEM_DataOut(dataOut[0]), .fault(fault[0]),
        .dbgState(dbgState[0])
    );

    mem_stage_ctrl #(.DEPTH(1024), .LATENCY(4), .ADDR_W(32)) dut1 (
        .clk(clk), .rst(rst), .req(req[1]), .ready(ready[1]), .busy(busy[1]),
        .Mem_WrEn(wrEn[1]), .Mem_Size(memSize[1]), .Mem_Signed(memSigned[1]),
        .ALU_MEM_Addr(addr[1]), .MEM_DataIn(dataIn[1]),
        .resp_valid(respValid[1]), .MEM_DataOut(dataOut[1]), .fault(fault[1]),
        .dbgState(dbgState[1])
    );

    // ----------------------------------------------------------- scoreboard ---
    logic [31:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic vecT mk(input logic w, input logic [1:0] s, input logic sg,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic [31:0] e, input logic f);
        vecT v;
        v.wrEn = w; v.size = s; v.sgn = sg; v.addr = a; v.data = d;
        v.expOut = e; v.expFault = f;
        return v;
    endfunction

    // ------------------------------------------------------- driver tasks ---
    // Issue one access on instance d and wait (bounded) for its response.
    // lat counts cycles after the accept edge, sampled on negedges.
    task automatic access(input int d, input vecT v, output int lat,
                          output logic [31:0] out, output logic flt);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!ready[d] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        wrEn[d] = v.wrEn; memSize[d] = v.size; memSigned[d] = v.sgn;
        addr[d] = v.addr; dataIn[d] = v.data; req[d] = 1'b1;
        @(posedge clk);
        #1 req[d] = 1'b0;
        lat = 0; out = 32'hDEAD_DEAD; flt = 1'bx;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (respValid[d]) begin
                lat = i; out = dataOut[d]; flt = fault[d];
                break;
            end
        end
    endtask

    task automatic runVec(input int d, input int k, input vecT v, input int expLat);
        int          lat;
        logic [31:0] out;
        logic        flt;
        logic [31:0] e;
        exp_q.push_back(v.expOut);
        access(d, v, lat, out, flt);
        e = exp_q.pop_front();
        chk($sformatf("d%0d vec%0d latency", d, k), 32'(lat), 32'(expLat));
        chk($sformatf("d%0d vec%0d data", d, k), out, e);
        chk($sformatf("d%0d vec%0d fault", d, k), {31'd0, flt}, {31'd0, v.expFault});
        @(negedge clk);
        chk($sformatf("d%0d vec%0d pulse end", d, k), {31'd0, respValid[d]}, 32'd0);
        chk($sformatf("d%0d vec%0d ready after", d, k), {31'd0, ready[d]}, 32'd1);
        chk($sformatf("d%0d vec%0d data hold", d, k), dataOut[d], e);
    endtask

    vecT vecs0[22];
    vecT vecs1[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Vectors for LATENCY=1 (instance 0).
        vecs0[0]  = mk(1, SZ_WORD, 0, 32'h4,    32'h0000_001F, 32'h0000_0000, 0);
        vecs0[1]  = mk(0, SZ_WORD, 0, 32'h4,    32'h0,         32'h0000_001F, 0);
        vecs0[2]  = mk(1, SZ_BYTE, 0, 32'h5,    32'hFFFF_FF80, 32'h0000_0000, 0);
        vecs0[3]  = mk(0, SZ_BYTE, 1, 32'h5,    32'h0,         32'hFFFF_FF80, 0);
        vecs0[4]  = mk(0, SZ_BYTE, 0, 32'h5,    32'h0,         32'h0000_0080, 0);
        vecs0[5]  = mk(0, SZ_WORD, 0, 32'h4,    32'h0,         32'h0000_801F, 0);
        vecs0[6]  = mk(1, SZ_WORD, 0, 32'h0,    32'h0000_0000, 32'h0000_0000, 0);
        vecs0[7]  = mk(1, SZ_HALF, 0, 32'h2,    32'h1234_BEEF, 32'h0000_0000, 0);
        vecs0[8]  = mk(0, SZ_HALF, 1, 32'h2,    32'h0,         32'hFFFF_BEEF, 0);
        vecs0[9]  = mk(0, SZ_WORD, 0, 32'h0,    32'h0,         32'hBEEF_0000, 0);
        vecs0[10] = mk(0, SZ_HALF, 0, 32'h2,    32'h0,         32'h0000_BEEF, 0);
        vecs0[11] = mk(0, SZ_WORD, 0, 32'h1004, 32'h0,         32'h0000_801F, 0);
        vecs0[12] = mk(1, 2'b11,   0, 32'h10,   32'hA5A5_0001, 32'h0000_0000, 0);
        vecs0[13] = mk(0, SZ_WORD, 1, 32'h10,   32'h0,         32'hA5A5_0001, 0);
        vecs0[14] = mk(1, SZ_WORD, 0, 32'h20,   32'h7F80_0102, 32'h0000_0000, 0);
        vecs0[15] = mk(0, SZ_BYTE, 1, 32'h23,   32'h0,         32'h0000_007F, 0);
        vecs0[16] = mk(0, SZ_BYTE, 1, 32'h22,   32'h0,         32'hFFFF_FF80, 0);
        vecs0[17] = mk(0, SZ_HALF, 1, 32'h20,   32'h0,         32'h0000_0102, 0);
        vecs0[18] = ALIGN ? mk(0, SZ_HALF, 1, 32'h23, 32'h0, 32'h0000_0000, 1)
                          : mk(0, SZ_HALF, 1, 32'h23, 32'h0, 32'h0000_7F80, 0);
        vecs0[19] = ALIGN ? mk(1, SZ_WORD, 0, 32'h6, 32'hCAFE_F00D, 32'h0, 1)
                          : mk(1, SZ_WORD, 0, 32'h6, 32'hCAFE_F00D, 32'h0, 0);
        vecs0[20] = ALIGN ? mk(0, SZ_WORD, 0, 32'h4, 32'h0, 32'h0000_801F, 0)
                          : mk(0, SZ_WORD, 0, 32'h4, 32'h0, 32'hCAFE_F00D, 0);
        vecs0[21] = ALIGN ? mk(0, SZ_WORD, 0, 32'h6, 32'h0, 32'h0000_0000, 1)
                          : mk(0, SZ_WORD, 0, 32'h6, 32'h0, 32'hCAFE_F00D, 0);

        // Vectors for LATENCY=4 (instance 1); 0xFC3 -> word 0x3F0, lane 3.
        vecs1[0] = mk(1, SZ_WORD, 0, 32'hFC0,  32'h0000_0000, 32'h0, 0);
        vecs1[1] = mk(1, SZ_BYTE, 0, 32'hFC3,  32'h0000_009C, 32'h0, 0);
        vecs1[2] = mk(0, SZ_BYTE, 0, 32'hFC3,  32'h0,         32'h0000_009C, 0);
        vecs1[3] = mk(0, SZ_BYTE, 1, 32'hFC3,  32'h0,         32'hFFFF_FF9C, 0);
        vecs1[4] = mk(0, SZ_WORD, 0, 32'hFC0,  32'h0,         32'h9C00_0000, 0);
        vecs1[5] = mk(0, SZ_WORD, 0, 32'h1FC0, 32'h0,         32'h9C00_0000, 0);

        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; wrEn[d] = 1'b0; memSize[d] = 2'b00; memSigned[d] = 1'b0;
            addr[d] = 32'd0; dataIn[d] = 32'd0;
        end

        // Reset state.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d reset resp_valid", d), {31'd0, respValid[d]}, 32'd0);
            chk($sformatf("d%0d reset ready", d), {31'd0, ready[d]}, 32'd1);
            chk($sformatf("d%0d reset busy", d), {31'd0, busy[d]}, 32'd0);
            chk($sformatf("d%0d reset dataout", d), dataOut[d], 32'd0);
            chk($sformatf("d%0d reset fault", d), {31'd0, fault[d]}, 32'd0);
            chk($sformatf("d%0d reset state", d), {30'd0, dbgState[d]}, {30'd0, ST_IDLE});
        end

        for (int k = 0; k < 22; k++) runVec(0, k, vecs0[k], 1);
        for (int k = 0; k < 6; k++)  runVec(1, k, vecs1[k], 4);

        // Held req during busy: exactly two accepts in ten cycles.
        begin
            logic expReady [10];
            logic expResp  [10];
            for (int i = 0; i < 10; i++) begin
                expReady[i] = (i == 4) || (i == 9);
                expResp[i]  = (i == 3) || (i == 8);
            end
            @(negedge clk);
            wrEn[1] = 1'b0; memSize[1] = SZ_WORD; memSigned[1] = 1'b0;
            addr[1] = 32'hFC0; req[1] = 1'b1;
            @(posedge clk);
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                chk($sformatf("held req ready c%0d", i + 1), {31'd0, ready[1]}, {31'd0, expReady[i]});
                chk($sformatf("held req resp c%0d", i + 1), {31'd0, respValid[1]}, {31'd0, expResp[i]});
                if (i == 0) chk("held req state wait", {30'd0, dbgState[1]}, {30'd0, ST_WAIT});
                if (i == 3) chk("held req state resp", {30'd0, dbgState[1]}, {30'd0, ST_RESP});
                if (i == 8) begin
                    chk("held req second data", dataOut[1], 32'h9C00_0000);
                    req[1] = 1'b0;
                end
            end
        end

        // Reset on the edge that would commit a store: store is dropped.
        runVec(1, 100, mk(1, SZ_WORD, 0, 32'h8, 32'h1122_3344, 32'h0, 0), 4);
        wrEn[1] = 1'b1; memSize[1] = SZ_WORD; memSigned[1] = 1'b0;
        addr[1] = 32'h8; dataIn[1] = 32'h1234_5678; req[1] = 1'b1;
        @(posedge clk);
        #1 req[1] = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset-mid state wait", {30'd0, dbgState[1]}, {30'd0, ST_WAIT});
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset-mid resp_valid", {31'd0, respValid[1]}, 32'd0);
        chk("reset-mid ready", {31'd0, ready[1]}, 32'd1);
        chk("reset-mid dataout", dataOut[1], 32'd0);
        runVec(1, 101, mk(0, SZ_WORD, 0, 32'h8, 32'h0, 32'h1122_3344, 0), 4);

        // ------------------------------------------------------ final report ---
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
